// File: rtl/mpadd_seq_pkg.sv
// mpadd_seq_pkg: FSM state encodings and index-width helper shared by the
// multi-precision add/subtract sequencer.
package mpadd_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mpadd_seq_addsub.sv
// mpadd_seq_addsub: one-word adder/subtractor; carry=0 injects the subtract +1,
// carry=1 chains cin from the previous word.
module mpadd_seq_addsub #(
    parameter int WORD_SIZE = 8
) (
    input  logic [WORD_SIZE-1:0] x,
    input  logic [WORD_SIZE-1:0] y,
    input  logic                 sub,
    input  logic                 cin,
    input  logic                 carry,
    output logic [WORD_SIZE-1:0] sum,
    output logic                 cout
);

    logic ci;

    assign ci = carry ? cin : sub;
    assign {cout, sum} = {1'b0, x} + {1'b0, y ^ {WORD_SIZE{sub}}} + {{WORD_SIZE{1'b0}}, ci};

endmodule

// File: rtl/mpadd_seq.sv
// mpadd_seq: feeds wide operands LSW-first through one addsub word per cycle,
// chaining the carry and assembling the wide result plus cout/zero/ovf flags.
module mpadd_seq
    import mpadd_seq_pkg::*;
#(
    parameter  int WORD_SIZE = 8,
    parameter  int NUM_WORDS = 4,
    localparam int W         = WORD_SIZE * NUM_WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic         ovf
);

    localparam int IW = idx_width(NUM_WORDS);

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic                 sub_q, sub_d, carry_q, carry_d, zacc_q, zacc_d;
    logic                 cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
    logic [WORD_SIZE-1:0] x_w, y_w, sum_w;
    logic                 co_w, last_w, accept_w;

    assign x_w      = a_q[int'(idx_q) * WORD_SIZE +: WORD_SIZE];
    assign y_w      = b_q[int'(idx_q) * WORD_SIZE +: WORD_SIZE];
    assign last_w   = idx_q == IW'(NUM_WORDS - 1);
    assign accept_w = start && state_q != S_RUN;

    assign ready  = state_q != S_RUN;
    assign done   = state_q == S_DONE;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

    mpadd_seq_addsub #(.WORD_SIZE(WORD_SIZE)) u_addsub (
        .x    (x_w),
        .y    (y_w),
        .sub  (sub_q),
        .cin  (carry_q),
        .carry(idx_q != '0),
        .sum  (sum_w),
        .cout (co_w)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (accept_w) begin
            a_d     = a;
            b_d     = b;
            sub_d   = sub;
            idx_d   = '0;
            carry_d = 1'b0;
            zacc_d  = 1'b1;
            state_d = S_RUN;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
        if (state_q == S_RUN) begin
            acc_d[int'(idx_q) * WORD_SIZE +: WORD_SIZE] = sum_w;
            carry_d = co_w;
            zacc_d  = zacc_q & (sum_w == '0);
            idx_d   = idx_q + 1'b1;
            // Flags land on the same edge as the most significant word.
            if (last_w) begin
                state_d  = S_DONE;
                idx_d    = '0;
                result_d = acc_d;
                cout_d   = co_w;
                zero_d   = zacc_d;
                ovf_d    = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (sum_w[WORD_SIZE-1] != a_q[W-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mpadd_seq.sv
// tb_mpadd_seq: directed and back-to-back operations on a 4x8-bit sequencer,
// expected results queued at issue and checked when done pulses.
module tb_mpadd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, done, cout, zero, ovf;
    logic [31:0] result;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mpadd_seq #(.WORD_SIZE(8), .NUM_WORDS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .result(result),
        .cout  (cout),
        .zero  (zero),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t        e;
        logic [32:0] full;
        full = {1'b0, x} + {1'b0, s ? ~y : y} + {32'd0, s};
        e.r  = full[31:0];
        e.c  = full[32];
        e.z  = (full[31:0] == 32'd0);
        e.v  = (x[31] == (y[31] ^ s)) && (full[31] != x[31]);
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, result, e.r);
            chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
            chk({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
            chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.v});
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic ts, input bit noise);
        int n;
        int extra;
        sb.push_back(model(ta, tb_, ts));
        a = ta;
        b = tb_;
        sub = ts;
        start = 1'b1;
        @(negedge clk);
        n = 1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, ready}, 32'd0);
        while (!done && n < 20) begin
            if (noise) begin
                a = $urandom;
                b = $urandom;
                sub = ~sub;
                start = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, 32'd5);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        pop_check(tag);
        if (noise) begin
            extra = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk({tag, "_extra_done"}, extra, 32'd0);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, cout, zero, ovf, done}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_op("ff_plus_1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        run_op("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op("sub_52_10", 32'd52, 32'd10, 1'b1, 1'b0);
        run_op("sub_0_1", 32'd0, 32'd1, 1'b1, 1'b0);
        run_op("ovf_add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op("ovf_sub", 32'h80000000, 32'h00000001, 1'b1, 1'b1);
        run_op("mixed", 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);

        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                chk("b2b_done", {31'd0, done}, {31'd0, c % 5 == 0});
                if (done) pop_check("b2b");
            end
            if (c < 20) begin
                a = $urandom;
                b = $urandom;
                sub = 1'($urandom);
                start = 1'b1;
                if (c % 5 == 0) sb.push_back(model(a, b, sub));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_drained", 32'(sb.size()), 32'd0);

        run_op("pre_rst", 32'h01020304, 32'h10203040, 1'b0, 1'b0);
        a = 32'h11111111;
        b = 32'h22222222;
        sub = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_flags", {28'd0, cout, zero, ovf, done}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("post_rst_sub", 32'h00000100, 32'h00000001, 1'b1, 1'b0);
        run_op("post_rst_add", 32'h00FF00FF, 32'h00010001, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
